// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
// Holds the FSM state enum, the requester/select sizes and the rotating-priority pick.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Search order is last+1, last+2, last+3, last+4 (mod 4); scanning backwards
    // lets the nearest set requester overwrite any farther one.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4.sv
// Existing 4:1 single-bit datapath mux: y = d[{a1,a2}] while a3 is high.
// a3 is an active-high output enable; with a3 low the output is forced to 0.
module mux4 (
    input  logic [3:0] d,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    output logic       y
);

    assign y = a3 & d[{a1, a2}];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select controller in front of the mux4 datapath.
// Optional MUX4_ARB_BURST_EN keeps a grant for up to MAX_BURST beats; otherwise every beat rotates.
//
// state | meaning
// IDLE  | no requester granted, grant = 0
// GRANT | sel/grant own the mux, beats flow on req[sel] && ack
module mux4_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    input  logic       ack,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       dout,
    output logic       dout_valid,
    output logic       busy
);
    import mux4_arb_pkg::*;

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("mux4_rr_arbiter: MAX_BURST must be in 1..15");
    end

    state_t             state;
    logic [SEL_W-1:0]   last;
    logic               xfer;
    logic               drop;
    logic               last_beat;
    logic               done;
    logic [NUM_REQ-1:0] req_masked;
    pick_t              idle_pick;
    pick_t              rearb_pick;

`ifdef MUX4_ARB_BURST_EN
    logic [3:0] burst_cnt;
`endif

    assign busy       = (state == GRANT);
    assign dout_valid = (state == GRANT) && req[sel];

    always_comb begin
        xfer       = dout_valid && ack;
        drop       = (state == GRANT) && !req[sel];
`ifdef MUX4_ARB_BURST_EN
        last_beat  = xfer && (burst_cnt == 4'(MAX_BURST - 1));
`else
        last_beat  = xfer;
`endif
        done       = drop || last_beat;
        req_masked = req;
        // A dropped requester must not win its own re-arbitration.
        if (drop) begin
            req_masked[sel] = 1'b0;
        end
        idle_pick  = rr_pick(req, last);
        rearb_pick = rr_pick(req_masked, sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            last  <= 2'd3;
`ifdef MUX4_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick.found) begin
                        state <= GRANT;
                        grant <= onehot(idle_pick.idx);
                        sel   <= idle_pick.idx;
`ifdef MUX4_ARB_BURST_EN
                        burst_cnt <= '0;
`endif
                    end else begin
                        grant <= '0;
                    end
                end
                GRANT: begin
                    if (done) begin
                        last <= sel;
                        // Hand-off happens on the release edge itself: no idle bubble.
                        if (rearb_pick.found) begin
                            grant <= onehot(rearb_pick.idx);
                            sel   <= rearb_pick.idx;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
`ifdef MUX4_ARB_BURST_EN
                        burst_cnt <= '0;
`endif
                    end
`ifdef MUX4_ARB_BURST_EN
                    else if (xfer) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    mux4 u_mux4 (
        .d  (din),
        .a1 (sel[1]),
        .a2 (sel[0]),
        .a3 (1'b1),
        .y  (dout)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter against a behavioural round-robin model.
// Works with MUX4_ARB_BURST_EN defined (bursts of MB beats) or undefined (one beat per grant).
module tb_mux4_rr_arbiter;

    localparam int MB  = 2;
`ifdef MUX4_ARB_BURST_EN
    localparam int EFF = MB;
`else
    localparam int EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    // model: who owns the line, who owned it last, beats accepted so far
    bit m_busy;
    int m_owner;
    int m_last;
    int m_beats;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .ack        (ack),
        .grant      (grant),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    assign obs = {grant, sel, busy, dout_valid, dout};

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = 3;
        m_beats = 0;
    endtask

    // Next requester after 'from' in circular order among the set bits of r, or -1.
    function automatic int next_after(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic [3:0] r;
        int         w;
        bit         beat;
        bit         dropped;
        if (!m_busy) begin
            w = next_after(req, m_last);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_beats = 0;
            end
        end else begin
            dropped = !req[m_owner];
            beat    = req[m_owner] && ack;
            if (beat) m_beats++;
            if (dropped || m_beats == EFF) begin
                m_last = m_owner;
                r = req;
                if (dropped) r[m_owner] = 1'b0;
                w = next_after(r, m_owner);
                m_beats = 0;
                if (w >= 0) m_owner = w;
                else        m_busy  = 1'b0;
            end
        end
    endtask

    function automatic logic [8:0] exp_vec();
        logic [3:0] g;
        g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_busy, m_busy && req[m_owner], din[m_owner]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        req = 4'b1111;
        ack = 1'b0;
        din = 4'($urandom);
        #3;
        checks++;
        if (grant !== 4'b0000 || dout_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: grant=%b valid=%b busy=%b sel=%0d, want 0000/0/0/0",
                     grant, dout_valid, busy, sel);
        end
        checks++;
        if (dout !== din[0]) begin
            errors++;
            $display("FAIL reset_dout: got %b want din[0]=%b", dout, din[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b sel=%0d busy=%b, want 0001/0/1", grant, sel, busy);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        apply_reset();
        req = 4'b1111;
        ack = 1'b1;
        tick();
        for (int n = 0; n < 9; n++) begin
            din = 4'($urandom);
            #1;
            want = 4'b0001 << ((n / EFF) % 4);
            checks++;
            if (grant !== want || busy !== 1'b1) begin
                errors++;
                $display("FAIL rotation_seq %0d: grant=%b busy=%b want %b/1", n, grant, busy, want);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rotation_model %0d: got %b want %b", n, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req = 4'b0100;
        ack = 1'b0;
        tick();
        for (int n = 0; n < 5 + 2 * EFF; n++) begin
            ack = (n >= 5);
            din = 4'($urandom);
            #1;
            checks++;
            if (grant !== 4'b0100 || sel !== 2'd2 || dout !== din[2] || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure %0d: grant=%b sel=%0d dout=%b valid=%b want 0100/2/%b/1",
                         n, grant, sel, dout, dout_valid, din[2]);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure_model %0d: got %b want %b", n, obs, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_drop();
        apply_reset();
        req = 4'b1010;
        ack = 1'b0;
        din = 4'($urandom);
        tick();
        checks++;
        if (grant !== 4'b0010 || sel !== 2'd1) begin
            errors++;
            $display("FAIL drop_initial: grant=%b sel=%0d want 0010/1", grant, sel);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        req = 4'b1000;
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL drop_model: got %b want %b", obs, exp_vec());
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_handoff: grant=%b sel=%0d busy=%b want 1000/3/1", grant, sel, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req = 4'b1000;
        ack = 1'b1;
        din = 4'($urandom);
        tick();
        #1;
        checks++;
        if (obs !== exp_vec() || grant !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_pre: got %b want %b", obs, exp_vec());
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (grant !== 4'b0000 || dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: grant=%b valid=%b busy=%b want 0000/0/0", grant, dout_valid, busy);
        end
        req = 4'b1111;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL midreset_regrant: grant=%b sel=%0d want 0001/0", grant, sel);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din = 4'($urandom);
            ack = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random %0d: req=%b ack=%b got %b want %b", n, req, ack, obs, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        din = 4'b0000;
        ack = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_backpressure();
        test_drop();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
